// File: rtl/wimax_stream_checker.sv
// Golden-pattern checker for PHY self-test: compares a valid-qualified symbol stream
// against a static golden frame and keeps error/frame statistics plus first-error capture.
module wimax_stream_checker #(
  parameter int DATA_W      = 1,
  parameter int FRAME_LEN   = 96,
  parameter int MSB_FIRST   = 1,
  parameter int ERR_CNT_W   = 8,
  parameter int FRAME_CNT_W = 16,
  localparam int IDX_W      = $clog2(FRAME_LEN)
) (
  input  logic                          clk,
  input  logic                          reset_N,
  input  logic                          clear,
  input  logic                          valid_in,
  input  logic [DATA_W-1:0]             data_in,
  input  logic [DATA_W*FRAME_LEN-1:0]   golden,
  input  logic [DATA_W-1:0]             cmp_mask,
  output logic                          pass,
  output logic                          fail,
  output logic [ERR_CNT_W-1:0]          err_count,
  output logic [FRAME_CNT_W-1:0]        frame_count,
  output logic                          frame_done,
  output logic                          frame_err,
  output logic                          first_err_valid,
  output logic [FRAME_CNT_W-1:0]        first_err_frame,
  output logic [IDX_W-1:0]              first_err_index
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  idx;
  logic              frame_err_acc;
  logic [DATA_W-1:0] gold_sym;
  logic              mism;
  logic              last_sym;

  // Golden symbol for the current index; symbol order depends on MSB_FIRST.
  always_comb begin
    gold_sym = '0;
    for (int k = 0; k < FRAME_LEN; k++) begin
      if (idx == IDX_W'(k)) begin
        if (MSB_FIRST != 0)
          gold_sym = golden[DATA_W*(FRAME_LEN-1-k) +: DATA_W];
        else
          gold_sym = golden[DATA_W*k +: DATA_W];
      end
    end
  end

  assign mism     = |((data_in ^ gold_sym) & cmp_mask);
  assign last_sym = (idx == IDX_W'(FRAME_LEN-1));
  assign pass     = (frame_count != '0) && (err_count == '0);

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N)
      state <= IDLE;
    else if (clear)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // No alignment search: the first valid symbol is taken as index 0 and RUN holds.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_in) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      idx             <= '0;
      frame_err_acc   <= 1'b0;
      fail            <= 1'b0;
      err_count       <= '0;
      frame_count     <= '0;
      frame_done      <= 1'b0;
      frame_err       <= 1'b0;
      first_err_valid <= 1'b0;
      first_err_frame <= '0;
      first_err_index <= '0;
    end else if (clear) begin
      idx             <= '0;
      frame_err_acc   <= 1'b0;
      fail            <= 1'b0;
      err_count       <= '0;
      frame_count     <= '0;
      frame_done      <= 1'b0;
      frame_err       <= 1'b0;
      first_err_valid <= 1'b0;
      first_err_frame <= '0;
      first_err_index <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (valid_in) begin
        idx <= last_sym ? '0 : idx + 1'b1;
        if (mism) begin
          fail <= 1'b1;
          if (err_count != '1)
            err_count <= err_count + 1'b1;
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_frame <= frame_count;
            first_err_index <= idx;
          end
        end
        // Frame end reports the accumulated flag and restarts it for the next frame.
        if (last_sym) begin
          frame_done    <= 1'b1;
          frame_err     <= mism | frame_err_acc;
          frame_err_acc <= 1'b0;
          if (frame_count != '1)
            frame_count <= frame_count + 1'b1;
        end else if (mism) begin
          frame_err_acc <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wimax_stream_checker.sv
// Directed bench: three checker instances (serial MSB-first, {I,Q} pairs, serial LSB-first
// with a 4-bit error counter) driven one at a time from a linear sequence of steps.
module tb_wimax_stream_checker;

  localparam logic [95:0] GOLD1 = 96'hA5C3_1F0E_9B27_44D8_3CE1_5A0F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_N, clear;

  logic         va, da, ma;
  logic [95:0]  ga;
  logic         pass_a, fail_a, done_a, ferr_a, fev_a;
  logic [7:0]   err_a;
  logic [15:0]  frames_a, fef_a;
  logic [6:0]   fei_a;

  logic         vb;
  logic [1:0]   db, mb;
  logic [191:0] gb;
  logic         pass_b, fail_b, done_b, ferr_b, fev_b;
  logic [7:0]   err_b;
  logic [15:0]  frames_b, fef_b;
  logic [6:0]   fei_b;

  logic         vc, dc, mc;
  logic [95:0]  gc;
  logic         pass_c, fail_c, done_c, ferr_c, fev_c;
  logic [3:0]   err_c;
  logic [15:0]  frames_c, fef_c;
  logic [6:0]   fei_c;

  int tests = 0;
  int errors = 0;

  wimax_stream_checker #(.DATA_W(1), .FRAME_LEN(96), .MSB_FIRST(1), .ERR_CNT_W(8), .FRAME_CNT_W(16)) dut_a (
    .clk(clk), .reset_N(reset_N), .clear(clear), .valid_in(va), .data_in(da), .golden(ga),
    .cmp_mask(ma), .pass(pass_a), .fail(fail_a), .err_count(err_a), .frame_count(frames_a),
    .frame_done(done_a), .frame_err(ferr_a), .first_err_valid(fev_a),
    .first_err_frame(fef_a), .first_err_index(fei_a));

  wimax_stream_checker #(.DATA_W(2), .FRAME_LEN(96), .MSB_FIRST(1), .ERR_CNT_W(8), .FRAME_CNT_W(16)) dut_b (
    .clk(clk), .reset_N(reset_N), .clear(clear), .valid_in(vb), .data_in(db), .golden(gb),
    .cmp_mask(mb), .pass(pass_b), .fail(fail_b), .err_count(err_b), .frame_count(frames_b),
    .frame_done(done_b), .frame_err(ferr_b), .first_err_valid(fev_b),
    .first_err_frame(fef_b), .first_err_index(fei_b));

  wimax_stream_checker #(.DATA_W(1), .FRAME_LEN(96), .MSB_FIRST(0), .ERR_CNT_W(4), .FRAME_CNT_W(16)) dut_c (
    .clk(clk), .reset_N(reset_N), .clear(clear), .valid_in(vc), .data_in(dc), .golden(gc),
    .cmp_mask(mc), .pass(pass_c), .fail(fail_c), .err_count(err_c), .frame_count(frames_c),
    .frame_done(done_c), .frame_err(ferr_c), .first_err_valid(fev_c),
    .first_err_frame(fef_c), .first_err_index(fei_c));

  function automatic logic symA(input int i);
    return ga[95 - (i % 96)];
  endfunction

  function automatic logic [1:0] symB(input int i);
    return gb[191 - 2*(i % 96) -: 2];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus for the selected unit (0=a, 1=b, 2=c); outputs are sampled #1 after the edge.
  task automatic applyStimulus(input int unit, input logic v, input logic [1:0] d, input logic clr);
    va = 1'b0; vb = 1'b0; vc = 1'b0;
    da = 1'b0; db = 2'b00; dc = 1'b0;
    clear = clr;
    case (unit)
      0: begin va = v; da = d[0]; end
      1: begin vb = v; db = d;    end
      default: begin vc = v; dc = d[0]; end
    endcase
    @(posedge clk);
    #1;
  endtask

  initial begin
    ga = GOLD1;
    gb = {GOLD1, ~GOLD1};
    for (int i = 0; i < 96; i++) gc[i] = GOLD1[95 - i];
    ma = 1'b1; mc = 1'b1; mb = 2'b10;
    va = 1'b0; vb = 1'b0; vc = 1'b0; da = 1'b0; db = 2'b00; dc = 1'b0;
    clear = 1'b0;
    reset_N = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_N = 1'b1;

    checkOutput("reset_pass", pass_a, 0);
    checkOutput("reset_fail", fail_a, 0);
    checkOutput("reset_err", err_a, 0);
    checkOutput("reset_frames", frames_a, 0);
    checkOutput("reset_fev", fev_a, 0);
    checkOutput("reset_done", done_a, 0);

    // T1: two clean frames back to back
    for (int i = 0; i < 192; i++) begin
      applyStimulus(0, 1'b1, {1'b0, symA(i)}, 1'b0);
      checkOutput("t1_done", done_a, ((i % 96) == 95));
      if ((i % 96) == 95) checkOutput("t1_ferr", ferr_a, 0);
    end
    applyStimulus(0, 1'b0, 2'b00, 1'b0);
    checkOutput("t1_done_idle", done_a, 0);
    checkOutput("t1_frames", frames_a, 2);
    checkOutput("t1_err", err_a, 0);
    checkOutput("t1_pass", pass_a, 1);
    checkOutput("t1_fail", fail_a, 0);
    checkOutput("t1_fev", fev_a, 0);

    // T2: flip symbol 10 of frame 1, then symbol 20 of frame 2 must not overwrite the capture
    applyStimulus(0, 1'b0, 2'b00, 1'b1);
    checkOutput("t2_clr_frames", frames_a, 0);
    checkOutput("t2_clr_pass", pass_a, 0);
    for (int i = 0; i <= 212; i++) begin
      applyStimulus(0, 1'b1, {1'b0, symA(i) ^ ((i == 106) || (i == 212))}, 1'b0);
      if (i == 95) checkOutput("t2_pass_f0", pass_a, 1);
      if ((i % 96) == 95) begin
        checkOutput("t2_done", done_a, 1);
        checkOutput("t2_ferr", ferr_a, (i == 191));
      end
      if (i == 191) begin
        checkOutput("t2_err", err_a, 1);
        checkOutput("t2_fail", fail_a, 1);
        checkOutput("t2_pass", pass_a, 0);
        checkOutput("t2_frames", frames_a, 2);
        checkOutput("t2_fev", fev_a, 1);
        checkOutput("t2_fef", fef_a, 1);
        checkOutput("t2_fei", fei_a, 10);
      end
    end
    checkOutput("t2_err2", err_a, 2);
    checkOutput("t2_fef_kept", fef_a, 1);
    checkOutput("t2_fei_kept", fei_a, 10);

    // T5: clear with valid at idx 50 discards that symbol and restarts at idx 0
    applyStimulus(0, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 50; i++) applyStimulus(0, 1'b1, {1'b0, symA(i) ^ (i == 5)}, 1'b0);
    checkOutput("t5_pre_err", err_a, 1);
    applyStimulus(0, 1'b1, {1'b0, ~symA(50)}, 1'b1);
    checkOutput("t5_clr_err", err_a, 0);
    checkOutput("t5_clr_fail", fail_a, 0);
    checkOutput("t5_clr_frames", frames_a, 0);
    checkOutput("t5_clr_fev", fev_a, 0);
    checkOutput("t5_clr_fei", fei_a, 0);
    checkOutput("t5_clr_fef", fef_a, 0);
    checkOutput("t5_clr_done", done_a, 0);
    checkOutput("t5_clr_pass", pass_a, 0);
    for (int i = 0; i < 96; i++) begin
      applyStimulus(0, 1'b1, {1'b0, symA(i)}, 1'b0);
      if (i == 0) checkOutput("t5_idx0_err", err_a, 0);
    end
    checkOutput("t5_done", done_a, 1);
    checkOutput("t5_frames", frames_a, 1);
    checkOutput("t5_err", err_a, 0);
    checkOutput("t5_pass", pass_a, 1);

    // T5b: asynchronous reset mid-frame
    for (int i = 0; i < 30; i++) applyStimulus(0, 1'b1, {1'b0, symA(i) ^ (i == 3)}, 1'b0);
    checkOutput("t5b_pre_fail", fail_a, 1);
    reset_N = 1'b0;
    #1;
    checkOutput("t5b_rst_err", err_a, 0);
    checkOutput("t5b_rst_fail", fail_a, 0);
    checkOutput("t5b_rst_frames", frames_a, 0);
    checkOutput("t5b_rst_fev", fev_a, 0);
    @(posedge clk);
    #1;
    reset_N = 1'b1;
    for (int i = 0; i < 96; i++) applyStimulus(0, 1'b1, {1'b0, symA(i)}, 1'b0);
    checkOutput("t5b_frames", frames_a, 1);
    checkOutput("t5b_err", err_a, 0);
    checkOutput("t5b_pass", pass_a, 1);
    checkOutput("t5b_fail", fail_a, 0);

    // T3: {I,Q} pairs with valid toggling, Q corrupted on every symbol
    applyStimulus(1, 1'b0, 2'b00, 1'b1);
    for (int s = 0; s < 96; s++) begin
      applyStimulus(1, 1'b1, symB(s) ^ 2'b01, 1'b0);
      if (s == 95) checkOutput("t3_done", done_b, 1);
      applyStimulus(1, 1'b0, 2'b00, 1'b0);
      if (s == 95) checkOutput("t3_done_gap", done_b, 0);
    end
    checkOutput("t3_err", err_b, 0);
    checkOutput("t3_pass", pass_b, 1);
    checkOutput("t3_frames", frames_b, 1);
    checkOutput("t3_fail", fail_b, 0);
    mb = 2'b11;
    applyStimulus(1, 1'b0, 2'b00, 1'b1);
    for (int s = 0; s < 96; s++) begin
      applyStimulus(1, 1'b1, symB(s) ^ 2'b01, 1'b0);
      if (s == 95) checkOutput("t3m_ferr", ferr_b, 1);
      applyStimulus(1, 1'b0, 2'b00, 1'b0);
    end
    checkOutput("t3m_err", err_b, 96);
    checkOutput("t3m_fail", fail_b, 1);
    checkOutput("t3m_pass", pass_b, 0);
    checkOutput("t3m_frames", frames_b, 1);
    checkOutput("t3m_fev", fev_b, 1);
    checkOutput("t3m_fef", fef_b, 0);
    checkOutput("t3m_fei", fei_b, 0);

    // T4: inverted frame saturates the 4-bit error counter
    applyStimulus(2, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 96; i++) begin
      applyStimulus(2, 1'b1, {1'b0, ~symA(i)}, 1'b0);
      if (i == 13) checkOutput("t4_err14", err_c, 14);
      if (i == 15) checkOutput("t4_err16", err_c, 15);
      if (i == 95) checkOutput("t4_ferr", ferr_c, 1);
    end
    checkOutput("t4_err", err_c, 15);
    checkOutput("t4_fail", fail_c, 1);
    checkOutput("t4_pass", pass_c, 0);
    checkOutput("t4_frames", frames_c, 1);
    checkOutput("t4_fev", fev_c, 1);
    checkOutput("t4_fei", fei_c, 0);

    // T6: LSB-first instance with bit-reversed golden sees the T1 stream as clean
    applyStimulus(2, 1'b0, 2'b00, 1'b1);
    for (int i = 0; i < 192; i++) begin
      applyStimulus(2, 1'b1, {1'b0, symA(i)}, 1'b0);
      if ((i % 96) == 95) checkOutput("t6_done", done_c, 1);
    end
    checkOutput("t6_frames", frames_c, 2);
    checkOutput("t6_err", err_c, 0);
    checkOutput("t6_pass", pass_c, 1);
    checkOutput("t6_fail", fail_c, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
